qlf_updown_counter: RTL and testbench
=====================================

Name: qlf_updown_counter

Overview:
- Parametrised successor to the fixed 16-bit up counter.
- Configurable width and modulus (terminal value), with up/down direction, parallel load, and a wrap or saturate mode.
- Produces a registered terminal-count pulse and a sticky overflow flag.
- Used as a general counter/timer in the qlf_k4n8 test designs. Maps to LUT+FF fabric with no hard blocks.

Parameters:
- WIDTH, 16, counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1, terminal value. Counting sequence is 0..MAX_VAL; must be ≤ 2**WIDTH-1.
- SATURATE, 0, boundary mode: 0 = wrap around, 1 = hold at the boundary.
- PRESCALE, 4, divide ratio for the optional prescaler; legal range 2..65535. Ignored unless QLF_COUNTER_PRESCALER_EN is defined.

Ports:
- clk  input  1  rising-edge clock; all logic lives in this single clock domain.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; level sensitive.
- up_down  input  1  direction: 1 = increment, 0 = decrement. Sampled only on count cycles.
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  value to load.
- ovf_clr  input  1  clears ovf_sticky.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- ovf_sticky  output  1  sticky boundary-event flag.

Behaviour:
- Reset values:
  - Synchronous reset, sampled at the clk edge.
  - count=0, tc=0, ovf_sticky=0. The prescaler counter also resets to 0.
- Priority per edge: reset > load > count step > hold.
- Load:
  - count <= min(load_value, MAX_VAL); values above MAX_VAL are clamped.
  - A load does not assert tc or set ovf_sticky.
  - Load overrides enable on the same cycle.
- Count step:
  - Occurs when `tick` is high and load is low.
  - `tick` = enable when the prescaler is compiled out.
- Up step:
  - If count < MAX_VAL, then count+1.
  - If count == MAX_VAL, the boundary event fires: with SATURATE=0, count <= 0; with SATURATE=1, count holds at MAX_VAL.
- Down step:
  - If count > 0, then count-1.
  - If count == 0, the boundary event fires: with SATURATE=0, count <= MAX_VAL; with SATURATE=1, count holds at 0.
- Boundary event:
  - tc=1 on the cycle after the event edge, i.e. the same edge that updates count. Otherwise tc=0.
  - In saturate mode, a boundary event fires on every attempted step at the limit, so tc pulses repeatedly while held.
- Arithmetic:
  - Internal compare and add use WIDTH bits.
  - No intermediate value may exceed WIDTH bits; MAX_VAL compare is exact.
- ovf_sticky:
  - Set on any boundary event.
  - Cleared by ovf_clr.
  - If set and clear coincide, set wins and the flag stays 1.
- Latency:
  - count and tc update one cycle after the sampled inputs.
  - No combinational path from inputs to outputs.
- A direction change mid-sequence takes effect on the next count step; nothing else changes.
- Reset asserted mid-sequence overrides everything on that edge, including load and pending prescaler state.

Optional Feature:
- Macro: QLF_COUNTER_PRESCALER_EN.
- Defined:
  - A prescaler counts enabled cycles from 0 to PRESCALE-1.
  - `tick`=1 only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - The prescaler holds when enable=0.
  - load or reset zeroes the prescaler.
  - Net effect: count steps once per PRESCALE enabled cycles.
- Undefined:
  - No prescaler logic is instantiated; `tick`=enable.
  - PRESCALE has no effect.

Decomposition:
- Package qlf_counter_pkg holds:
  - boundary-mode constants MODE_WRAP=0, MODE_SAT=1;
  - direction constants DIR_DOWN=0, DIR_UP=1;
  - a function clog2 used to size the prescaler.
- One sub-module, qlf_counter_prescaler:
  - parametrised by PRESCALE;
  - ports clk, reset, enable, clr, tick;
  - instantiated only under QLF_COUNTER_PRESCALER_EN.

Test Plan:
All scenarios use WIDTH=4, MAX_VAL=9 unless noted.
- Wrap up: SATURATE=0, reset, then enable=1, up_down=1 for 12 cycles. count runs 1..9, 0, 1, 2. tc pulses exactly once, on the 9→0 edge. ovf_sticky=1 afterwards.
- Wrap down: load_value=1, then up_down=0 for 3 steps. count runs 1, 0, 9, 8. tc is high for one cycle on the 0→9 edge.
- Saturate: SATURATE=1, load 8, count up for 4 steps. count goes 9, 9, 9, 9. tc is high on each of the 3 held steps. Then ovf_clr together with a held step leaves ovf_sticky=1; ovf_clr alone clears it to 0.
- Load priority and clamp: load=1, load_value=15, enable=1 on the same cycle. count=9 (clamped) and tc=0. Then reset=1 together with load=1 gives count=0, tc=0, ovf_sticky=0.
- Enable gating: toggle enable 1,0,1,0 with up_down=1 from 0. count goes 1, 1, 2, 2. A direction flip while enable=0 produces no change.
- Prescaler (macro defined, PRESCALE=3): enable held high for 9 cycles gives count 0→3 with steps every third cycle. A load asserted on the 2nd prescaler cycle restarts the 3-cycle spacing from the load.

Source files
------------

// File: rtl/qlf_counter_pkg.sv
// Shared constants and helpers for the qlf up/down counter family.
package qlf_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Bits needed to hold 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/qlf_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last enabled cycle of each period.
module qlf_counter_prescaler
    import qlf_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qlf_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate, tc pulse and sticky overflow.
// Optional prescaler on the count enable when QLF_COUNTER_PRESCALER_EN is defined.
module qlf_updown_counter
    import qlf_counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter logic             SATURATE = MODE_WRAP,
    parameter int unsigned      PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf_sticky
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("qlf_updown_counter: WIDTH out of range");
    end
    if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
        $error("qlf_updown_counter: PRESCALE out of range");
    end

    logic tick;

`ifdef QLF_COUNTER_PRESCALER_EN
    qlf_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clr    (load),
        .tick   (tick)
    );
`else
    assign tick = enable;
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             boundary;

    always_comb begin
        count_d  = count_q;
        boundary = 1'b0;
        if (load) begin
            count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (tick) begin
            if (up_down == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    boundary = 1'b1;
                    count_d  = (SATURATE == MODE_SAT) ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    boundary = 1'b1;
                    count_d  = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        tc_d  = boundary;
        // Set beats clear when both happen on the same edge.
        ovf_d = boundary | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_qlf_updown_counter.sv
// Bench for qlf_updown_counter: wrap and saturate instances against a spec-level model.
module tb_qlf_updown_counter;

    localparam int PRE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       ovf_clr = 1'b0;

    logic [3:0] count_w, count_s;
    logic       tc_w, tc_s, ovf_w, ovf_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qlf_updown_counter #(
        .WIDTH    (4),
        .MAX_VAL  (4'd9),
        .SATURATE (1'b0),
        .PRESCALE (PRE)
    ) u_wrap (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .ovf_clr    (ovf_clr),
        .count      (count_w),
        .tc         (tc_w),
        .ovf_sticky (ovf_w)
    );

    qlf_updown_counter #(
        .WIDTH    (4),
        .MAX_VAL  (4'd9),
        .SATURATE (1'b1),
        .PRESCALE (PRE)
    ) u_sat (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .ovf_clr    (ovf_clr),
        .count      (count_s),
        .tc         (tc_s),
        .ovf_sticky (ovf_s)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: index 0 = wrap instance, 1 = saturate instance.
    int mc[2];
    int mtc[2];
    int movf[2];
    int mpre = 0;
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        bit t;
        bit hit;
`ifdef QLF_COUNTER_PRESCALER_EN
        t = enable && (mpre == PRE - 1);
        if (reset || load) mpre = 0;
        else if (enable) mpre = (mpre == PRE - 1) ? 0 : mpre + 1;
`else
        t = enable;
`endif
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mc[i] = 0;
                mtc[i] = 0;
                movf[i] = 0;
            end else if (load) begin
                mc[i] = (int'(load_value) > 9) ? 9 : int'(load_value);
                mtc[i] = 0;
                movf[i] = movf[i] & ~int'(ovf_clr);
            end else begin
                hit = 1'b0;
                if (t) begin
                    if (up_down) begin
                        if (mc[i] == 9) begin
                            hit = 1'b1;
                            mc[i] = (i == 1) ? 9 : 0;
                        end else mc[i] = mc[i] + 1;
                    end else begin
                        if (mc[i] == 0) begin
                            hit = 1'b1;
                            mc[i] = (i == 1) ? 0 : 9;
                        end else mc[i] = mc[i] - 1;
                    end
                end
                mtc[i] = int'(hit);
                movf[i] = hit ? 1 : (movf[i] & ~int'(ovf_clr));
            end
        end
        if (reset) mvalid = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (mvalid) begin
            chk("model count_w", int'(count_w), mc[0]);
            chk("model tc_w", int'(tc_w), mtc[0]);
            chk("model ovf_w", int'(ovf_w), movf[0]);
            chk("model count_s", int'(count_s), mc[1]);
            chk("model tc_s", int'(tc_s), mtc[1]);
            chk("model ovf_s", int'(ovf_s), movf[1]);
        end
    end

    task automatic step(input logic r, input logic en, input logic ud, input logic ld,
                        input logic [3:0] lv, input logic clr);
        @(negedge clk);
        reset = r;
        enable = en;
        up_down = ud;
        load = ld;
        load_value = lv;
        ovf_clr = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(1, 0, 1, 0, 0, 0);
        chk("reset count", int'(count_w), 0);
        chk("reset tc", int'(tc_w), 0);
        chk("reset ovf", int'(ovf_w), 0);

`ifndef QLF_COUNTER_PRESCALER_EN
        // Wrap up: 1..9, 0, 1, 2 with a single tc on 9->0.
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 0, 0, 0);
            chk("wrap up count", int'(count_w), (i + 1) % 10);
            chk("wrap up tc", int'(tc_w), (i == 9) ? 1 : 0);
        end
        chk("wrap up ovf", int'(ovf_w), 1);

        // Wrap down from 1: 0, 9, 8.
        step(0, 0, 0, 1, 4'd1, 0);
        chk("load 1", int'(count_w), 1);
        step(0, 1, 0, 0, 0, 0);
        chk("down 1->0", int'(count_w), 0);
        chk("down 1->0 tc", int'(tc_w), 0);
        step(0, 1, 0, 0, 0, 0);
        chk("down 0->9", int'(count_w), 9);
        chk("down 0->9 tc", int'(tc_w), 1);
        step(0, 1, 0, 0, 0, 0);
        chk("down 9->8", int'(count_w), 8);
        chk("down 9->8 tc", int'(tc_w), 0);

        // Saturate: clear flag, load 8, step up 4 times.
        step(0, 0, 1, 0, 0, 1);
        chk("sat ovf cleared", int'(ovf_s), 0);
        step(0, 0, 1, 1, 4'd8, 0);
        chk("sat load 8", int'(count_s), 8);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 0, 0);
            chk("sat count", int'(count_s), 9);
            chk("sat tc", int'(tc_s), (i > 0) ? 1 : 0);
        end
        step(0, 1, 1, 0, 0, 1);
        chk("sat set+clr ovf", int'(ovf_s), 1);
        chk("sat set+clr tc", int'(tc_s), 1);
        step(0, 0, 1, 0, 0, 1);
        chk("sat clr ovf", int'(ovf_s), 0);
        chk("sat clr tc", int'(tc_s), 0);

        // Load beats enable and clamps; reset beats load.
        step(0, 1, 1, 1, 4'd15, 0);
        chk("clamp count", int'(count_w), 9);
        chk("clamp tc", int'(tc_w), 0);
        chk("clamp count sat", int'(count_s), 9);
        step(1, 1, 1, 1, 4'd15, 0);
        chk("rst+load count", int'(count_w), 0);
        chk("rst+load tc", int'(tc_w), 0);
        chk("rst+load ovf", int'(ovf_w), 0);

        // Enable gating and a direction flip while idle.
        step(0, 1, 1, 0, 0, 0);
        chk("gate 1", int'(count_w), 1);
        step(0, 0, 1, 0, 0, 0);
        chk("gate 2", int'(count_w), 1);
        step(0, 1, 1, 0, 0, 0);
        chk("gate 3", int'(count_w), 2);
        step(0, 0, 1, 0, 0, 0);
        chk("gate 4", int'(count_w), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("idle dir flip", int'(count_w), 2);
`else
        // Prescaled: one step per three enabled cycles.
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 1, 0, 0, 0);
            chk("pre count", int'(count_w), (i + 1) / 3);
        end
        step(1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 4'd0, 0);
        chk("pre load", int'(count_w), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, 0);
            chk("pre after load", int'(count_w), (i == 2) ? 1 : 0);
        end
`endif

        step(0, 0, 1, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
